minmax_tracker: RTL

Streaming window min/max tracker that sits directly downstream of the team's cascaded greater/equal/smaller magnitude comparator. Each accepted N-bit sample is compared against the running maximum and minimum, and the register is updated from the greater/equal/smaller result. After WINDOW samples the block presents the window's max and min for one cycle, then starts a new window. It is used for peak/trough capture on the lab boards.

---
 rtl/minmax_tracker.sv | 139 +++++++++++++
 1 files changed

// File: rtl/minmax_tracker.sv
// Streaming window min/max tracker fed by greater-than magnitude compares.
// Define MINMAX_IDX_EN to add first-occurrence index outputs for max/min.

// MSB-first cascaded magnitude compare: gt = (a > b), unsigned.
module minmax_cmp #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         gt
);
  logic lt;
  always_comb begin
    gt = 1'b0;
    lt = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!gt && !lt) begin
        gt = a[i] & ~b[i];
        lt = ~a[i] & b[i];
      end
    end
  end
endmodule

module minmax_tracker #(
  parameter  int N      = 4,
  parameter  int WINDOW = 8,
  localparam int CW     = $clog2(WINDOW + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  output logic          in_ready,
  input  logic          clear,
  output logic [CW-1:0] count_o,
  output logic [N-1:0]  max_o,
  output logic [N-1:0]  min_o,
  output logic          out_valid
`ifdef MINMAX_IDX_EN
  ,
  output logic [CW-1:0] max_idx_o,
  output logic [CW-1:0] min_idx_o
`endif
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} st_t;

  localparam logic [CW-1:0] WIN_C = CW'(WINDOW);

  st_t state, state_nxt;

  // Compare lanes: [0] in_data > max_o, [1] min_o > in_data (i.e. in_data < min_o).
  logic [1:0][N-1:0] opa, opb;
  logic [1:0]        gt_v;

  assign opa[0] = in_data;
  assign opb[0] = max_o;
  assign opa[1] = min_o;
  assign opb[1] = in_data;

  for (genvar l = 0; l < 2; l++) begin : g_cmp
    minmax_cmp #(.N(N)) u_cmp (
      .a  (opa[l]),
      .b  (opb[l]),
      .gt (gt_v[l])
    );
  end

  logic          accept, load_first, load_acc;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = count_o + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (WINDOW == 1) ? DONE : ACC;
      ACC:  if (accept && cnt_inc == WIN_C) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  // Samples offered alongside clear are dropped, hence clear masks accept.
  always_comb begin
    in_ready   = (state != DONE) && !rst;
    accept     = in_valid && in_ready && !clear;
    load_first = accept && (state == IDLE);
    load_acc   = accept && (state == ACC);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_o   <= '0;
      max_o     <= '0;
      min_o     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state_nxt == DONE);
      if (state == DONE) begin
        count_o <= '0;
      end else if (load_first) begin
        count_o <= CW'(1);
        max_o   <= in_data;
        min_o   <= in_data;
      end else if (load_acc) begin
        count_o <= cnt_inc;
        if (gt_v[0]) max_o <= in_data;
        if (gt_v[1]) min_o <= in_data;
      end
    end
  end

`ifdef MINMAX_IDX_EN
  // count_o is the 0-based slot of the sample being accepted in ACC.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      max_idx_o <= '0;
      min_idx_o <= '0;
    end else if (load_first) begin
      max_idx_o <= '0;
      min_idx_o <= '0;
    end else if (load_acc) begin
      if (gt_v[0]) max_idx_o <= count_o;
      if (gt_v[1]) min_idx_o <= count_o;
    end
  end
`else
  // Index tracking compiled out.
`endif

endmodule
